unsigned_div_ctrl: RTL and testbench

Sequential controller for the 32-bit unsigned restoring divider. It owns the dividend/divisor/remainder registers and the iteration counter. Each cycle it drives the existing combinational ALU in subtract mode and consumes the ALU's result/carry to decide quotient bits. It sits directly upstream and downstream of the ALU: it feeds src1/src2/funct and takes back result/carry.

---
 rtl/div_pkg.sv | 21 ++
 rtl/unsigned_div_ctrl.sv | 151 +++++++++++++++
 tb/tb_unsigned_div_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the unsigned restoring divider and its ALU.
package div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  // ALU function codes
  localparam logic [5:0] FUNCT_AND = 6'b000000;
  localparam logic [5:0] FUNCT_OR  = 6'b000001;
  localparam logic [5:0] FUNCT_XOR = 6'b000010;
  localparam logic [5:0] FUNCT_ADD = 6'b001000;
  localparam logic [5:0] FUNCT_SUB = 6'b001010;
  localparam logic [5:0] FUNCT_SLT = 6'b001011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/unsigned_div_ctrl.sv
// Sequential controller for a 32-bit unsigned restoring divider.
// Each RUN cycle one partial-remainder subtraction is delegated to an external
// combinational ALU; the borrow decides the quotient bit. Results are registered.
module unsigned_div_ctrl #(
  parameter int unsigned WIDTH     = div_pkg::WIDTH,
  parameter logic [5:0]  FUNCT_SUB = div_pkg::FUNCT_SUB,
  parameter int unsigned CNT_W     = div_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [5:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  import div_pkg::*;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic [WIDTH-1:0] rem_hi_q, rem_hi_d;
  logic [WIDTH-1:0] rem_lo_q, rem_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zdiv_q, zdiv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] shifted;
  logic             ovf;
  logic             qbit;

  // Datapath shift and ALU drive; ALU sees zeros outside RUN
  always_comb begin
    shifted   = {rem_hi_q[WIDTH-2:0], rem_lo_q[WIDTH-1]};
    ovf       = rem_hi_q[WIDTH-1];
    // When the shifted-out bit is set the true partial remainder exceeds the
    // divisor regardless of borrow, and the wrapped ALU difference is exact.
    qbit      = ovf | ~alu_carry;
    alu_src1  = '0;
    alu_src2  = '0;
    alu_funct = FUNCT_SUB;
    if (state_q == RUN) begin
      alu_src1 = shifted;
      alu_src2 = dreg_q;
    end
  end

  // Next-state and next-output computation
  always_comb begin
    state_d  = state_q;
    dreg_d   = dreg_q;
    rem_hi_d = rem_hi_q;
    rem_lo_d = rem_lo_q;
    cnt_d    = cnt_q;
    zdiv_d   = zdiv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dreg_d   = divisor;
          rem_hi_d = '0;
          rem_lo_d = dividend;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          if (divisor == '0) begin
            zdiv_d  = 1'b1;
            state_d = FIN;
          end else begin
            zdiv_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_hi_d = qbit ? alu_result : shifted;
        rem_lo_d = {rem_lo_q[WIDTH-2:0], qbit};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (zdiv_q) begin
          quot_d = '1;
          rem_d  = rem_lo_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = rem_lo_q;
          rem_d  = rem_hi_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset wins over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dreg_q   <= '0;
      rem_hi_q <= '0;
      rem_lo_q <= '0;
      cnt_q    <= '0;
      zdiv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      dreg_q   <= dreg_d;
      rem_hi_q <= rem_hi_d;
      rem_lo_q <= rem_lo_d;
      cnt_q    <= cnt_d;
      zdiv_q   <= zdiv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_unsigned_div_ctrl.sv
// Unit bench for unsigned_div_ctrl with a behavioural subtract-only ALU.
module tb_unsigned_div_ctrl;

  localparam int unsigned W = 32;
  localparam logic [5:0] SUB = 6'b001010;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [W-1:0] alu_src1, alu_src2, alu_result;
  logic [5:0]   alu_funct;
  logic         alu_carry;

  unsigned_div_ctrl #(.WIDTH(W), .FUNCT_SUB(SUB), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // ALU model: carry is the borrow of an unsigned subtraction
  logic [W:0] diff;
  always_comb begin
    diff = {1'b0, alu_src1} - {1'b0, alu_src2};
    alu_result = '0;
    alu_carry  = 1'b0;
    if (alu_funct == SUB) begin
      alu_result = diff[W-1:0];
      alu_carry  = diff[W];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  dc;
  } exp_t;

  exp_t sb[$];

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("quotient", 64'(quotient), 64'(e.q));
        check_eq("remainder", 64'(remainder), 64'(e.r));
        check_eq("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        check_eq("latency", 64'(cyc), 64'(e.dc));
        check_eq("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Drive one request at a negedge; it is accepted at the following edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int unsigned acc;
    acc = cyc + 1;
    start = 1'b1; dividend = a; divisor = b;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.dc = acc + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.dc = acc + W + 1;
    end
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; dividend = '0; divisor = '0;
    check_eq("busy_after_start", 64'(busy), 64'(b != '0));
  endtask

  task automatic wait_empty();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    issue(a, b);
    wait_empty();
  endtask

  initial begin
    int unsigned base;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_quot", 64'(quotient), 64'd0);
    check_eq("rst_rem", 64'(remainder), 64'd0);
    check_eq("rst_alu_src1", 64'(alu_src1), 64'd0);
    check_eq("rst_alu_funct", 64'(alu_funct), 64'(SUB));

    op(32'd100, 32'd7);
    op(32'hFFFF_FFFF, 32'd1);
    op(32'h8000_0000, 32'hFFFF_FFFF);
    op(32'hFFFF_FFFE, 32'h8000_0001);
    op(32'd5, 32'd0);
    op(32'd9, 32'd3);
    op(32'd0, 32'd13);
    op(32'd6, 32'd6);

    // Requests while busy (mid-run and in the final busy cycle) are ignored
    @(negedge clk);
    base = cyc;
    issue(32'd100, 32'd7);
    while (cyc < base + 10) @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 1 + W) @(negedge clk);
    check_eq("busy_fin_cycle", 64'(busy), 64'd1);
    start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    @(negedge clk);
    start = 1'b0; dividend = '0; divisor = '0;
    wait_empty();
    repeat (40) @(negedge clk);
    check_eq("no_extra_op_busy", 64'(busy), 64'd0);

    // Reset in the middle of a division: no done pulse, outputs cleared
    @(negedge clk);
    base = cyc;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_quot", 64'(quotient), 64'd0);
    check_eq("midrst_rem", 64'(remainder), 64'd0);
    repeat (40) @(negedge clk);
    op(32'd20, 32'd6);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      a = $urandom();
      b = $urandom() >> $urandom_range(0, 31);
      op(a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
